// File: rtl/game_pkg.sv
// Shared game constants and the hit-controller state encoding.
package game_pkg;
    localparam logic [3:0] GS_TITLE   = 4'd0;
    localparam logic [3:0] GS_START   = 4'd1;
    localparam logic [3:0] PLAY_STATE = 4'd2;
    localparam logic [3:0] GS_OVER    = 4'd3;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_ARMED,
        HS_HIT_ACK,
        HS_INVULN,
        HS_DEAD
    } hit_state_t;
endpackage

// File: rtl/player_hit_ctrl_if.sv
// Fireball hit handshake: attacker raises fireball_exist, the player side answers with fireball_hit.
interface player_hit_ctrl_if;
    logic [9:0] fireballX;
    logic [9:0] fireballY;
    logic [9:0] fireballS;
    logic       fireball_exist;
    logic       fireball_hit;

    modport master (output fireballX, fireballY, fireballS, fireball_exist, input fireball_hit);
    modport slave  (input fireballX, fireballY, fireballS, fireball_exist, output fireball_hit);
endinterface

// File: rtl/box_overlap.sv
// Combinational centre/half-size box overlap test; distances taken as |a-b| so nothing underflows.
module box_overlap (
    input  logic [9:0] i_ax,
    input  logic [9:0] i_ay,
    input  logic [9:0] i_as,
    input  logic [9:0] i_bx,
    input  logic [9:0] i_by,
    input  logic [9:0] i_bs,
    output logic       o_overlap
);
    logic [10:0] w_dx, w_dy, w_sum;

    always_comb begin
        w_dx      = (i_ax >= i_bx) ? {1'b0, i_ax - i_bx} : {1'b0, i_bx - i_ax};
        w_dy      = (i_ay >= i_by) ? {1'b0, i_ay - i_by} : {1'b0, i_by - i_ay};
        w_sum     = {1'b0, i_as} + {1'b0, i_bs};
        o_overlap = (w_dx <= w_sum) && (w_dy <= w_sum);
    end
endmodule

// File: rtl/player_hit_ctrl.sv
// Player side of the fireball handshake: life loss, hit acknowledge, invulnerability window and death flag.
module player_hit_ctrl
    import game_pkg::*;
#(
    parameter int MAX_LIFE      = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int ACK_MAX       = 8,
    parameter int BLINK_BIT     = 2
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [3:0]             game_state,
    input  logic [9:0]             BallX,
    input  logic [9:0]             BallY,
    input  logic [9:0]             BallS,
    player_hit_ctrl_if.slave       fb,
    output logic [2:0]             player_life,
    output logic                   player_invuln,
    output logic                   player_blink,
    output logic                   player_dead
);
    localparam logic [2:0] LIFE_INIT = 3'(MAX_LIFE);
    localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES - 1);
    localparam logic [3:0] ACK_LAST  = 4'(ACK_MAX - 1);

    hit_state_t r_state, w_state_nxt;
    logic [2:0] r_life, w_life_nxt;
    logic       r_hit, w_hit_nxt;
    logic [3:0] r_ack_cnt, w_ack_nxt;
    logic [7:0] r_inv_cnt, w_inv_nxt;
    logic       w_overlap, w_hit_det, w_play;

    box_overlap u_overlap (
        .i_ax     (fb.fireballX),
        .i_ay     (fb.fireballY),
        .i_as     (fb.fireballS),
        .i_bx     (BallX),
        .i_by     (BallY),
        .i_bs     (BallS),
        .o_overlap(w_overlap)
    );

    assign w_hit_det = w_overlap & fb.fireball_exist;
    assign w_play    = (game_state == PLAY_STATE);

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= HS_IDLE;
            r_life    <= LIFE_INIT;
            r_hit     <= 1'b0;
            r_ack_cnt <= '0;
            r_inv_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_life    <= w_life_nxt;
            r_hit     <= w_hit_nxt;
            r_ack_cnt <= w_ack_nxt;
            r_inv_cnt <= w_inv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_life_nxt  = r_life;
        w_hit_nxt   = r_hit;
        w_ack_nxt   = r_ack_cnt;
        w_inv_nxt   = r_inv_cnt;
        // Leaving play wins over everything, including a hit detected this frame.
        if (!w_play) begin
            w_state_nxt = HS_IDLE;
            w_hit_nxt   = 1'b0;
            if (r_state == HS_IDLE) w_life_nxt = LIFE_INIT;
        end else begin
            case (r_state)
                HS_IDLE: begin
                    w_life_nxt  = LIFE_INIT;
                    w_state_nxt = HS_ARMED;
                end
                HS_ARMED: begin
                    if (w_hit_det) begin
                        w_life_nxt  = r_life - 3'd1;
                        w_hit_nxt   = 1'b1;
                        w_ack_nxt   = '0;
                        w_state_nxt = HS_HIT_ACK;
                    end
                end
                HS_HIT_ACK: begin
                    if (!fb.fireball_exist || r_ack_cnt == ACK_LAST) begin
                        w_hit_nxt = 1'b0;
                        if (r_life == 3'd0) begin
                            w_state_nxt = HS_DEAD;
                        end else begin
                            w_inv_nxt   = INV_LOAD;
                            w_state_nxt = HS_INVULN;
                        end
                    end else begin
                        w_ack_nxt = r_ack_cnt + 4'd1;
                    end
                end
                HS_INVULN: begin
                    if (r_inv_cnt == 8'd0) w_state_nxt = HS_ARMED;
                    else                   w_inv_nxt   = r_inv_cnt - 8'd1;
                end
                HS_DEAD: begin
                    w_hit_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = HS_IDLE;
                    w_hit_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign fb.fireball_hit = r_hit;
    assign player_life     = r_life;
    assign player_invuln   = (r_state == HS_INVULN);
    assign player_blink    = player_invuln & r_inv_cnt[BLINK_BIT];
    assign player_dead     = (r_state == HS_DEAD);
endmodule
